// File: rtl/mod_counter_gen.sv
// Parametrised modulo up/down counter with wrap/saturate, load, terminal count and sticky overflow.
// Optional enable prescaler compiled in with COUNTER_PRESCALE_EN.
module mod_counter_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MODULUS    = 256,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
    input  logic                  up_i,
    input  logic                  sat_i,
    input  logic                  clr_ovf_i,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    output logic [WIDTH-1:0]      count_o,
    output logic                  tc_o,
    output logic                  wrap_o,
    output logic                  ovf_o,
    output logic                  oe_o
);

    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE_W < 1)
    begin : g_bad_params
        $error("mod_counter_gen: illegal parameter combination");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             step;
    logic             at_top, at_bot, at_edge;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = (div_q == prescale_i);

    // Divider only moves on enabled cycles; a load restarts the prescale period.
    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = '0;
        end else if (ena_i) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign at_top  = (count_q == MaxVal);
    assign at_bot  = (count_q == '0);
    assign at_edge = up_i ? at_top : at_bot;
    assign step    = ena_i & tick & ~load_i;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf_i;
        if (load_i) begin
            count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
        end else if (step) begin
            if (at_edge) begin
                // Boundary hit: overflow is set even when saturating, and wins over clear.
                ovf_d  = 1'b1;
                wrap_d = ~sat_i;
                if (!sat_i) begin
                    count_d = up_i ? '0 : MaxVal;
                end
            end else begin
                count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign ovf_o   = ovf_q;
    assign tc_o    = at_edge;
    assign oe_o    = ena_i & ~at_edge;

endmodule

// File: doc/mod_counter_gen.md
# mod_counter_gen

Parametrised modulo up/down counter, the general-purpose successor to the fixed 8-bit free-running counter used in our Tiny Tapeout user designs. Adds configurable width and modulus, direction control, wrap-or-saturate mode, synchronous load, a terminal-count flag and a sticky overflow flag. An optional enable prescaler is compiled in by macro. It drives `uo_out`/`uio_out` directly or feeds other blocks as a timebase.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 2..16.
- `MODULUS`, 256: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `PRESCALE_W`, 4: prescaler select width; only used with `COUNTER_PRESCALE_EN`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  count enable.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `sat`  in  1  boundary mode: 1 = saturate, 0 = wrap.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `prescale`  in  PRESCALE_W  tick divider select; present only with `COUNTER_PRESCALE_EN`.
- `count`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal count (combinational): `count==MODULUS-1` when `up=1`, `count==0` when `up=0`.
- `wrap`  out  1  one-cycle pulse (registered) on a wrap event.
- `ovf`  out  1  sticky boundary-hit flag (registered).
- `oe`  out  1  `ena & ~tc`, for driving `uio_oe`.

## Operation
- Priority per edge: `rst` (async) > `load` > count step.
- Load:
  - `count <= min(load_val, MODULUS-1)`.
  - Prescaler divider cleared; `wrap` = 0 that cycle; `ovf` unaffected.
- Step condition: `ena & tick & ~load`. `tick` = 1 without the prescaler.
- Up step:
  - `count < MODULUS-1`: `count+1`.
  - At `MODULUS-1`:
    - `sat=0`: `count <= 0`, `wrap` = 1, `ovf` set.
    - `sat=1`: hold at `MODULUS-1`, `wrap` = 0, `ovf` set.
- Down step mirrors up step:
  - `count > 0`: `count-1`.
  - At 0: wrap to `MODULUS-1` (`sat=0`) or hold (`sat=1`); `ovf` set in both cases; `wrap` pulses only in the wrap case.
- `ovf`: cleared by `clr_ovf`. Set wins over clear in the same cycle.
- Changing `up` or `sat` mid-run takes effect on the next step; there is no other state.
- All arithmetic is WIDTH bits; comparisons are against the MODULUS-1 constant; no intermediate overflow.

## Timing
- Reset values: `count`=0, `wrap`=0, `ovf`=0, divider=0.
- `tc` and `oe` after reset: `tc`=1 if `up=0`, else 0; `oe` follows from `tc`.
- Latency: `count`, `wrap` and `ovf` change on the first rising edge after a qualifying cycle (1-cycle latency).
- `wrap` is high for exactly one cycle: the cycle in which `count` first shows the wrapped value.
- `tc`/`oe` respond combinationally to `count`, `up` and `ena` in the same cycle.
- `rst` asserted mid-count clears all state immediately, without waiting for `clk`. Deassertion is synchronised externally.

## Configuration
- Macro: `COUNTER_PRESCALE_EN`.
- Defined:
  - `prescale` port exists; internal PRESCALE_W-bit divider.
  - Divider advances while `ena`=1 and holds while `ena`=0.
  - `tick` = 1 when divider == `prescale`; divider then returns to 0.
  - Net effect: one step every `prescale+1` enabled cycles; `prescale`=0 gives a step every enabled cycle.
- Undefined: no `prescale` port, no divider; `tick` tied to 1.

## Test plan
- Reset (WIDTH=8, MODULUS=256): assert `rst` mid-count at `count`=0x37 with no clock edge -> `count`=0, `wrap`=0, `ovf`=0 immediately; with `up=1`, `tc`=0 and `oe`=`ena`.
- Wrap up (MODULUS=10, `sat`=0, `up`=1, `ena`=1): from reset, 12 cycles -> sequence 0..9,0,1,2; `tc`=1 at 9; `wrap`=1 only in the cycle showing 0; `ovf`=1 thereafter.
- Saturate down (MODULUS=10, `sat`=1, `up`=0): load 2, then 4 enabled cycles -> 1,0,0,0; `wrap` never asserted; `ovf`=1; assert `clr_ovf` -> `ovf`=0 next cycle.
- Load priority and clamp (MODULUS=10): assert `load`=1, `load_val`=15, `ena`=1 in the same cycle -> `count`=9 with no step; next enabled up step -> 0 with `wrap`=1.
- Flag race: `clr_ovf`=1 in the same cycle as a wrap -> `ovf`=1 (set wins).
- Prescaler (`COUNTER_PRESCALE_EN`, `prescale`=3): 12 cycles with `ena`=1 -> `count` increments on cycles 4, 8, 12; dropping `ena` for 2 cycles delays the next step by 2 cycles.
